// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA read engine.
package dma_pkg;

  localparam int BEAT_BYTES = 32;
  localparam int BEAT_SHIFT = 5;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_CALC  = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  typedef struct packed {
    logic [15:0] bytes;
    logic [31:0] addr;
  } cmd_t;

  // ceil(bytes / BEAT_BYTES); 12 bits because 0xFFFF bytes rounds up to 2048 beats
  function automatic logic [11:0] beats_of(input logic [15:0] bytes);
    return {1'b0, bytes[15:BEAT_SHIFT]} + 12'(|bytes[BEAT_SHIFT-1:0]);
  endfunction

endpackage

// File: rtl/dma_cmd_fifo.sv
// Single-clock showahead FIFO: rd_data always presents the head entry.
module dma_cmd_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;

  // Extra pointer bit distinguishes full from empty when the indices match
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk)
    if (wr_en && !full) mem[wr_ptr[AW-1:0]] <= wr_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && !full) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/dma_read_block.sv
// DMA read engine: splits commands into AVMM read bursts gated by data FIFO space.
// Optional DMA_RD_ERR_CHK_EN adds a sticky error for stray beats / misaligned addresses.
module dma_read_block
  import dma_pkg::*;
#(
  parameter int CMD_FIFO_DEPTH  = 32,
  parameter int MAX_BURST       = 16,
  parameter int DATA_FIFO_DEPTH = 256,
  parameter int USEDW_W         = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               dma_rd_fifo_command_req_i,
  input  logic [15:0]        dma_rd_bytes_to_transfer_i,
  input  logic [31:0]        dma_rd_addr_i,
  output logic               dma_rd_fifo_full_o,
  output logic [31:0]        rd_master_addr_o,
  output logic [10:0]        rd_master_bcount_o,
  output logic               rd_master_o,
  input  logic               rd_master_wait_req_i,
  input  logic [255:0]       rd_master_data_i,
  input  logic               rd_master_data_valid_i,
  input  logic [USEDW_W-1:0] dma_data_fifo_usedw_i,
  output logic [255:0]       dma_data_o,
  output logic               dma_data_fifo_wr_req_o,
  output logic               dma_rd_done_o,
  output logic               dma_rd_err_o
);

  cmd_t               head;
  logic               cmd_empty, pop;
  logic [2:0]         state, state_nxt;
  logic [31:0]        addr;
  logic [11:0]        remaining, outstanding, burst, burst_q, head_beats;
  logic signed [31:0] free;
  logic               accept, beat, beat_fwd;

  dma_cmd_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(CMD_FIFO_DEPTH)) u_cmd_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (dma_rd_fifo_command_req_i),
    .wr_data ({dma_rd_bytes_to_transfer_i, dma_rd_addr_i}),
    .rd_en   (pop),
    .rd_data (head),
    .full    (dma_rd_fifo_full_o),
    .empty   (cmd_empty)
  );

  assign head_beats = beats_of(head.bytes);
  assign pop        = (state == S_LOAD);
  assign accept     = (state == S_ISSUE) && !rd_master_wait_req_i;
  assign beat       = rd_master_data_valid_i && (outstanding != '0);
  assign burst      = (remaining > 12'(MAX_BURST)) ? 12'(MAX_BURST) : remaining;
  // Space left once every beat already requested has landed
  assign free       = 32'(DATA_FIFO_DEPTH) - 32'(dma_data_fifo_usedw_i) - 32'(outstanding);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!cmd_empty) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = (head_beats == '0) ? S_DONE : S_CALC;
      S_CALC:  if (free >= $signed(32'(burst))) state_nxt = S_ISSUE;
      S_ISSUE: if (accept) state_nxt = (remaining == burst_q) ? S_DRAIN : S_CALC;
      S_DRAIN: if (outstanding == '0) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      addr        <= '0;
      remaining   <= '0;
      outstanding <= '0;
      burst_q     <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_LOAD) begin
        addr        <= head.addr;
        remaining   <= head_beats;
        outstanding <= '0;
      end else begin
        outstanding <= outstanding + (accept ? burst_q : 12'd0) - {11'd0, beat};
      end
      if (state == S_CALC) burst_q <= burst;
      if (accept) begin
        remaining <= remaining - burst_q;
        addr      <= addr + (32'(burst_q) << BEAT_SHIFT);
      end
    end
  end

`ifdef DMA_RD_ERR_CHK_EN
  logic err;
  assign beat_fwd     = beat;
  assign dma_rd_err_o = err;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err <= 1'b0;
    else if ((rd_master_data_valid_i && outstanding == '0) ||
             (state == S_LOAD && head.addr[BEAT_SHIFT-1:0] != '0))
      err <= 1'b1;
  end
`else
  assign beat_fwd     = rd_master_data_valid_i;
  assign dma_rd_err_o = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dma_data_o             <= '0;
      dma_data_fifo_wr_req_o <= 1'b0;
    end else begin
      dma_data_o             <= rd_master_data_i;
      dma_data_fifo_wr_req_o <= beat_fwd;
    end
  end

  assign rd_master_o        = (state == S_ISSUE);
  assign rd_master_addr_o   = addr;
  assign rd_master_bcount_o = burst_q[10:0];
  assign dma_rd_done_o      = (state == S_DONE);

endmodule
